farm_top_core: RTL and testbench
================================

Name: farm_top_core

Overview:
- Top level of the FARM multicycle RV32I integer core.
- Contains instruction fetch (PC and instruction register), program memory, decode with a 32x32 register file, ALU/branch unit and a control-state generator.
- Each instruction takes exactly 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
- Exposes the current instruction and the address it was fetched from, for debug and trace.

Parameters:
- IMEM_WORDS, 256, program memory depth in 32-bit words; must be a power of two.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1 despite the name); sampled on rising clk.
- ins  output  32  contents of the instruction register (IR).
- ret_ad  output  32  PC_temp: address from which the IR contents were fetched.

Behaviour:
- Required hierarchy, because benches load and probe by path:
  - farm_pmi.imem.mem: word array [0:IMEM_WORDS-1], loadable by $readmemh.
  - farm_fetch.iag.PC: program counter.
  - farm_fetch.IR: instruction register.
  - farm_dec.RF: register file with task dump(first,last), which prints x[first..last] as hex.
  - cg.state: 2-bit control state.
- Reset (rst_n=1 at a clock edge):
  - state=FETCH(0), PC=RESET_PC, IR=0, PC_temp=0, all RF registers=0.
  - ins=0, ret_ad=0.
  - Imem contents are not cleared.
  - Reset mid-instruction aborts the instruction: no RF write and no PC update from that instruction.
- Imem read is combinational: mem[PC[log2(IMEM_WORDS)+1:2]]. Address bits above the index wrap; PC[1:0] are ignored.
- FETCH (state 0): IR<=imem word; PC_temp<=PC; next DECODE.
- DECODE (state 1): latch rs1/rs2 register values and the sign-extended immediate (I/S/B/U/J formats per RV32I); next EXECUTE.
- EXECUTE (state 2): compute the ALU result, branch condition and target; next WRITEBACK.
- WRITEBACK (state 3): write rd if the instruction writes; update PC; next FETCH.
- Supported opcodes:
  - LUI: rd=imm.
  - AUIPC: rd=PC_temp+imm.
  - JAL: rd=PC_temp+4; PC=PC_temp+imm.
  - JALR: rd=PC_temp+4; PC=(rs1+imm)&~1. rs1 is read before rd is written, so rd==rs1 is safe.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: PC=PC_temp+imm if taken, else PC_temp+4.
  - OP-IMM: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Any other opcode, including loads, stores, FENCE and SYSTEM, executes as a NOP: no RF write, PC=PC_temp+4.
- x0: reads always return 0; writes are ignored.
- Arithmetic is 32-bit, wrap-around, no overflow flag. Shift amount is the low 5 bits. SLT/BLT are signed; SLTU/BLTU are unsigned.
- PC arithmetic wraps modulo 2^32. A misaligned branch target is not trapped; the low bits are ignored on fetch.
- ins and ret_ad change only in FETCH, so they are stable for 4 cycles per instruction.
- First instruction timing: after reset deasserts, IR holds mem[0] one edge later; ret_ad=0.

Test Plan:
- Reset: hold rst_n=1 for 2 edges -> cg.state=0, PC=0, ins=0, ret_ad=0, RF.dump(0,10) shows all zeros. Release -> next edge ins=mem[0], ret_ad=0.
- Arithmetic: program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x1,x2 -> after 16 cycles x3=12, x4=32'hFFFF_FFFE; ret_ad sequence 0,4,8,C in 4-cycle steps.
- Jumps: jal x1,+8 at address 0 -> x1=4, next ret_ad=8. Then jalr x0,0(x1) -> next ret_ad=4.
- Branches: x1=x2=5, beq x1,x2,+12 at 0x8 -> next fetch at 0x14. With bne instead -> next fetch at 0xC. blt with x1=-1, x2=1 -> taken; bltu with the same values -> not taken.
- x0 and unknown opcode: addi x0,x0,9 -> x0 stays 0. Word 32'h0000_0003 (load) -> no RF change, PC advances by 4.
- Reset mid-operation: assert rst_n during EXECUTE of addi x5,x0,1 -> x5 stays 0; state=0 and PC=0 after the edge.

Source files
------------

// File: rtl/farm_top_core.sv
// FARM multicycle RV32I integer core.
// Every instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK (4 cycles).
// Ports:
//   clk    : single clock, all state changes on rising edge
//   rst_n  : synchronous reset, active HIGH despite the name
//   ins    : instruction register contents (debug/trace)
//   ret_ad : address the current instruction was fetched from

package farm_pkg;
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
endpackage

// Program memory word array; read is combinational, loaded externally.
module farm_imem #(parameter int unsigned WORDS = 256) (
    input  logic [$clog2(WORDS)-1:0] addr_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem [0:WORDS-1];
    assign rdata_o = mem[addr_i];
endmodule

// Program memory interface: word index from PC, upper bits wrap, PC[1:0] ignored.
module farm_pmi #(parameter int unsigned IMEM_WORDS = 256) (
    input  logic [31:0] pc_i,
    output logic [31:0] rdata_o
);
    localparam int unsigned IW = $clog2(IMEM_WORDS);
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[31:IW+2], pc_i[1:0]};
    farm_imem #(.WORDS(IMEM_WORDS)) imem (.addr_i(pc_i[IW+1:2]), .rdata_o(rdata_o));
endmodule

// Instruction address generator: holds the program counter.
module farm_iag #(parameter logic [31:0] RESET_PC = 32'h0000_0000) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [31:0] pc_next_i,
    output logic [31:0] pc_o
);
    logic [31:0] PC;
    always_ff @(posedge clk_i) begin
        if (rst_i)     PC <= RESET_PC;
        else if (we_i) PC <= pc_next_i;
    end
    assign pc_o = PC;
endmodule

// Fetch: PC, instruction register and the fetch address (PC_temp).
module farm_fetch #(parameter logic [31:0] RESET_PC = 32'h0000_0000) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_i,
    input  logic        pc_we_i,
    input  logic [31:0] pc_next_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] pc_temp_o
);
    logic [31:0] IR;
    logic [31:0] pc_temp_q;

    farm_iag #(.RESET_PC(RESET_PC)) iag (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(pc_we_i),
        .pc_next_i(pc_next_i), .pc_o(pc_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            IR        <= '0;
            pc_temp_q <= '0;
        end else if (fetch_i) begin
            IR        <= imem_rdata_i;
            pc_temp_q <= pc_o;
        end
    end
    assign ir_o      = IR;
    assign pc_temp_o = pc_temp_q;
endmodule

// 32x32 register file, x0 hardwired to zero.
module farm_rf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            regs[waddr_i] <= wdata_i;
        end
    end
    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs[raddr2_i];

    task automatic dump(input int first, input int last);
        for (int i = first; i <= last; i++) $display("x%0d = %08h", i, regs[i]);
    endtask
endmodule

// Decode: latch operands and the sign-extended immediate in DECODE.
module farm_dec (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        decode_i,
    input  logic        rf_we_i,
    input  logic [31:0] rf_wdata_i,
    input  logic [31:0] ir_i,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic [31:0] imm_o
);
    logic [31:0] rs1_d, rs2_d, imm_d;
    logic [31:0] rs1_q, rs2_q, imm_q;

    farm_rf RF (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(rf_we_i), .waddr_i(ir_i[11:7]),
        .wdata_i(rf_wdata_i), .raddr1_i(ir_i[19:15]), .raddr2_i(ir_i[24:20]),
        .rdata1_o(rs1_d), .rdata2_o(rs2_d)
    );

    always_comb begin
        imm_d = {{20{ir_i[31]}}, ir_i[31:20]};                                        // I
        case (ir_i[6:0])
            7'h37, 7'h17: imm_d = {ir_i[31:12], 12'h000};                             // U
            7'h6F: imm_d = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            7'h63: imm_d = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            7'h23: imm_d = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};                  // S
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
        end else if (decode_i) begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            imm_q <= imm_d;
        end
    end
    assign rs1_o = rs1_q;
    assign rs2_o = rs2_q;
    assign imm_o = imm_q;
endmodule

// Control-state generator: fixed 4-phase sequence.
module farm_cg (
    input  logic            clk_i,
    input  logic            rst_i,
    output farm_pkg::state_t state_o
);
    import farm_pkg::*;
    state_t state, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= FETCH;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            FETCH:     state_d = DECODE;
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = FETCH;
            default:   state_d = FETCH;
        endcase
    end
    assign state_o = state;
endmodule

module farm_top_core #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ins,
    output logic [31:0] ret_ad
);
    import farm_pkg::*;

    state_t      state;
    logic [31:0] pc, ir, pc_temp, imem_rdata, rs1, rs2, imm;
    logic [31:0] res_d, npc_d, res_q, npc_q, opb;
    logic        wen_d, wen_q, taken;
    logic [6:0]  opcode;
    logic [2:0]  f3;

    farm_cg cg (.clk_i(clk), .rst_i(rst_n), .state_o(state));

    farm_pmi #(.IMEM_WORDS(IMEM_WORDS)) farm_pmi (.pc_i(pc), .rdata_o(imem_rdata));

    farm_fetch #(.RESET_PC(RESET_PC)) farm_fetch (
        .clk_i(clk), .rst_i(rst_n), .fetch_i(state == FETCH),
        .pc_we_i(state == WRITEBACK), .pc_next_i(npc_q), .imem_rdata_i(imem_rdata),
        .pc_o(pc), .ir_o(ir), .pc_temp_o(pc_temp)
    );

    farm_dec farm_dec (
        .clk_i(clk), .rst_i(rst_n), .decode_i(state == DECODE),
        .rf_we_i(state == WRITEBACK && wen_q), .rf_wdata_i(res_q), .ir_i(ir),
        .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm)
    );

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign opb    = (opcode == 7'h33) ? rs2 : imm;

    always_comb begin
        case (f3)
            3'b000:  taken = (rs1 == rs2);
            3'b001:  taken = (rs1 != rs2);
            3'b100:  taken = ($signed(rs1) < $signed(rs2));
            3'b101:  taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  taken = (rs1 < rs2);
            3'b111:  taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        res_d = '0;
        wen_d = 1'b0;
        npc_d = pc_temp + 32'd4;
        case (opcode)
            7'h37: begin res_d = imm;                 wen_d = 1'b1; end
            7'h17: begin res_d = pc_temp + imm;       wen_d = 1'b1; end
            7'h6F: begin res_d = pc_temp + 32'd4;     wen_d = 1'b1; npc_d = pc_temp + imm; end
            7'h67: begin res_d = pc_temp + 32'd4;     wen_d = 1'b1; npc_d = (rs1 + imm) & ~32'd1; end
            7'h63: if (taken) npc_d = pc_temp + imm;
            7'h13, 7'h33: begin
                wen_d = 1'b1;
                case (f3)
                    // ir[30] selects SUB only for register ops; for ADDI it is an immediate bit
                    3'b000:  res_d = (opcode == 7'h33 && ir[30]) ? rs1 - opb : rs1 + opb;
                    3'b001:  res_d = rs1 << opb[4:0];
                    3'b010:  res_d = {31'd0, $signed(rs1) < $signed(opb)};
                    3'b011:  res_d = {31'd0, rs1 < opb};
                    3'b100:  res_d = rs1 ^ opb;
                    3'b101:  res_d = ir[30] ? 32'($signed(rs1) >>> opb[4:0]) : rs1 >> opb[4:0];
                    3'b110:  res_d = rs1 | opb;
                    default: res_d = rs1 & opb;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            res_q <= '0;
            npc_q <= RESET_PC;
            wen_q <= 1'b0;
        end else if (state == EXECUTE) begin
            res_q <= res_d;
            npc_q <= npc_d;
            wen_q <= wen_d;
        end
    end

    assign ins    = ir;
    assign ret_ad = pc_temp;
endmodule

// File: tb/tb_farm_top_core.sv
module tb_farm_top_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ins, ret_ad;
    int n_pass = 0;
    int n_total = 0;

    farm_top_core #(.IMEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .ret_ad(ret_ad)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [18];

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [11:0] b;
        logic [31:0] exp_pc;
    } br_t;
    br_t brs [4];

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] btype(input logic [12:0] off, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) dut.farm_pmi.imem.mem[i] = 32'h0;
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        dut.farm_pmi.imem.mem[idx] = w;
    endtask

    // lui+addi pair; the +0x800 compensates for addi sign-extending its low 12 bits
    task automatic load_li(input int idx, input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] hi;
        hi = (v + 32'h800) >> 12;
        load(idx, {hi[19:0], rd, 7'h37});
        load(idx + 1, itype(v[11:0], rd, 3'b000, rd, 7'h13));
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(2);
        rst_n = 1'b0;
    endtask

    initial begin
        logic [31:0] orall;

        vecs[0]  = '{"add",   32'd5,          32'd7,          rtype(7'h00, 2, 1, 3'b000, 3), 32'd12};
        vecs[1]  = '{"sub",   32'd5,          32'd7,          rtype(7'h20, 2, 1, 3'b000, 3), 32'hFFFF_FFFE};
        vecs[2]  = '{"sll",   32'd1,          32'h21,         rtype(7'h00, 2, 1, 3'b001, 3), 32'd2};
        vecs[3]  = '{"slt",   32'hFFFF_FFFF,  32'd1,          rtype(7'h00, 2, 1, 3'b010, 3), 32'd1};
        vecs[4]  = '{"sltu",  32'hFFFF_FFFF,  32'd1,          rtype(7'h00, 2, 1, 3'b011, 3), 32'd0};
        vecs[5]  = '{"xor",   32'hF0F0_F0F0,  32'h0FF0_0FF0,  rtype(7'h00, 2, 1, 3'b100, 3), 32'hFF00_FF00};
        vecs[6]  = '{"srl",   32'h8000_0000,  32'd4,          rtype(7'h00, 2, 1, 3'b101, 3), 32'h0800_0000};
        vecs[7]  = '{"sra",   32'h8000_0000,  32'd4,          rtype(7'h20, 2, 1, 3'b101, 3), 32'hF800_0000};
        vecs[8]  = '{"or",    32'h1234_0000,  32'h0000_5678,  rtype(7'h00, 2, 1, 3'b110, 3), 32'h1234_5678};
        vecs[9]  = '{"and",   32'hFFFF_0000,  32'h1234_5678,  rtype(7'h00, 2, 1, 3'b111, 3), 32'h1234_0000};
        vecs[10] = '{"addi",  32'h7FFF_FFFF,  32'd0,          itype(12'd1,   1, 3'b000, 3, 7'h13), 32'h8000_0000};
        vecs[11] = '{"slti",  32'hFFFF_FFFE,  32'd0,          itype(12'hFFF, 1, 3'b010, 3, 7'h13), 32'd1};
        vecs[12] = '{"sltiu", 32'd5,          32'd0,          itype(12'hFFF, 1, 3'b011, 3, 7'h13), 32'd1};
        vecs[13] = '{"xori",  32'h0000_FFFF,  32'd0,          itype(12'hFFF, 1, 3'b100, 3, 7'h13), 32'hFFFF_0000};
        vecs[14] = '{"srai",  32'h8000_0000,  32'd0,          itype(12'h41F, 1, 3'b101, 3, 7'h13), 32'hFFFF_FFFF};
        vecs[15] = '{"andi",  32'h1234_5678,  32'd0,          itype(12'h0FF, 1, 3'b111, 3, 7'h13), 32'h0000_0078};
        vecs[16] = '{"lui",   32'd0,          32'd0,          {20'hABCDE, 5'd3, 7'h37},            32'hABCD_E000};
        vecs[17] = '{"auipc", 32'd0,          32'd0,          {20'h00001, 5'd3, 7'h17},            32'h0000_1010};

        brs[0] = '{"beq_taken",  3'b000, 12'd5,   12'd5, 32'h14};
        brs[1] = '{"bne_not",    3'b001, 12'd5,   12'd5, 32'h0C};
        brs[2] = '{"blt_taken",  3'b100, 12'hFFF, 12'd1, 32'h14};
        brs[3] = '{"bltu_not",   3'b110, 12'hFFF, 12'd1, 32'h0C};

        // Reset state and arithmetic program
        clear_mem();
        load(0, itype(12'd5, 0, 3'b000, 1, 7'h13));
        load(1, itype(12'd7, 0, 3'b000, 2, 7'h13));
        load(2, rtype(7'h00, 2, 1, 3'b000, 3));
        load(3, rtype(7'h20, 2, 1, 3'b000, 4));
        rst_n = 1'b1;
        step(2);
        check("rst_state", 32'(dut.cg.state), 32'd0);
        check("rst_pc", dut.farm_fetch.iag.PC, 32'd0);
        check("rst_ins", ins, 32'd0);
        check("rst_ret_ad", ret_ad, 32'd0);
        orall = 32'd0;
        for (int i = 0; i <= 10; i++) orall |= dut.farm_dec.RF.regs[i];
        check("rst_rf_zero", orall, 32'd0);
        dut.farm_dec.RF.dump(0, 10);
        rst_n = 1'b0;
        step(1);
        check("first_ins", ins, 32'h0050_0093);
        check("first_ret_ad", ret_ad, 32'd0);
        for (int k = 1; k < 4; k++) begin
            step(4);
            check($sformatf("ret_ad_seq%0d", k), ret_ad, 32'(4 * k));
        end
        step(3);
        check("arith_x3", dut.farm_dec.RF.regs[3], 32'd12);
        check("arith_x4", dut.farm_dec.RF.regs[4], 32'hFFFF_FFFE);

        // Table-driven ALU vectors: x1=a, x2=b, then the op writes x3
        foreach (vecs[v]) begin
            clear_mem();
            load_li(0, 1, vecs[v].a);
            load_li(2, 2, vecs[v].b);
            load(4, vecs[v].instr);
            do_reset();
            step(20);
            check(vecs[v].name, dut.farm_dec.RF.regs[3], vecs[v].exp);
        end

        // Jumps; the jalr at 4 has rd==rs1 and an odd target
        clear_mem();
        load(0, jal(1, 21'd8));
        load(1, itype(12'd17, 1, 3'b000, 1, 7'h67));
        load(2, itype(12'd0, 1, 3'b000, 0, 7'h67));
        do_reset();
        step(4);
        check("jal_link", dut.farm_dec.RF.regs[1], 32'd4);
        step(1);
        check("jal_target", ret_ad, 32'd8);
        step(4);
        check("jalr_target", ret_ad, 32'd4);
        step(4);
        check("jalr_rd_rs1_target", ret_ad, 32'h14);
        check("jalr_rd_rs1_link", dut.farm_dec.RF.regs[1], 32'd8);

        // Branches at 0x8 with offset +12
        foreach (brs[b]) begin
            clear_mem();
            load(0, itype(brs[b].a, 0, 3'b000, 1, 7'h13));
            load(1, itype(brs[b].b, 0, 3'b000, 2, 7'h13));
            load(2, btype(13'd12, 2, 1, brs[b].f3));
            do_reset();
            step(13);
            check(brs[b].name, ret_ad, brs[b].exp_pc);
        end

        // x0 write ignored, unknown opcode is a NOP
        clear_mem();
        load(0, itype(12'd9, 0, 3'b000, 0, 7'h13));
        load(1, 32'h0000_0003);
        do_reset();
        step(4);
        check("x0_stays_zero", dut.farm_dec.RF.regs[0], 32'd0);
        step(5);
        check("nop_pc_advance", ret_ad, 32'd8);
        orall = 32'd0;
        for (int i = 0; i < 32; i++) orall |= dut.farm_dec.RF.regs[i];
        check("nop_rf_unchanged", orall, 32'd0);

        // Reset during EXECUTE aborts the instruction
        clear_mem();
        load(0, itype(12'd1, 0, 3'b000, 5, 7'h13));
        do_reset();
        step(2);
        check("pre_abort_state", 32'(dut.cg.state), 32'd2);
        rst_n = 1'b1;
        step(1);
        check("abort_state", 32'(dut.cg.state), 32'd0);
        check("abort_pc", dut.farm_fetch.iag.PC, 32'd0);
        check("abort_x5", dut.farm_dec.RF.regs[5], 32'd0);
        rst_n = 1'b0;
        step(4);
        check("after_abort_x5", dut.farm_dec.RF.regs[5], 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
